// File: rtl/spi_master_ctrl_if.sv
// Request/response and SPI pin bundle between the SPI frame master and its user/slave side.
interface spi_master_ctrl_if #(
  parameter int ADDR_SIZE = 8
);
  logic                 req_valid;
  logic                 req_ready;
  logic [1:0]           req_cmd;
  logic [ADDR_SIZE-1:0] req_data;
  logic                 SS_n;
  logic                 MOSI;
  logic                 MISO;
  logic                 busy;
  logic                 done;
  logic                 rd_valid;
  logic [ADDR_SIZE-1:0] rd_data;
  logic                 seq_err;

  modport master (
    input  req_valid, req_cmd, req_data, MISO,
    output req_ready, SS_n, MOSI, busy, done, rd_valid, rd_data, seq_err
  );

  modport slave (
    output req_valid, req_cmd, req_data, MISO,
    input  req_ready, SS_n, MOSI, busy, done, rd_valid, rd_data, seq_err
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// Frame-level SPI master: serialises {cmd, byte} MSB-first after a select bit and,
// for read-data frames, captures an ADDR_SIZE-bit MISO response after RD_GAP cycles.
module spi_master_ctrl #(
  parameter int ADDR_SIZE = 8,
  parameter int RD_GAP    = 2
) (
  input  logic            clk,
  input  logic            rst,
  spi_master_ctrl_if.master bus
);

  localparam int PW = ADDR_SIZE + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_SEL, S_SHIFT, S_GAP, S_RECV, S_END
  } state_t;

  state_t               r_state;
  logic [PW-1:0]        r_payload;
  logic [3:0]           r_bit_cnt;
  logic [3:0]           r_gap_cnt;
  logic [3:0]           r_rx_cnt;
  logic [ADDR_SIZE-2:0] r_rx_sr;
  logic                 r_ss_n;
  logic                 r_mosi;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_rd_valid;
  logic [ADDR_SIZE-1:0] r_rd_data;
  logic                 r_seq_err;
  logic                 r_rd_addr_seen;

  logic w_accept;
  logic w_is_rd_data;
  logic w_is_rd_addr;

  assign bus.req_ready = (r_state == S_IDLE) && !rst;
  assign w_accept      = bus.req_valid && bus.req_ready;
  assign w_is_rd_data  = (r_payload[PW-1:PW-2] == 2'b11);
  assign w_is_rd_addr  = (r_payload[PW-1:PW-2] == 2'b10);

  assign bus.SS_n     = r_ss_n;
  assign bus.MOSI     = r_mosi;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_data  = r_rd_data;
  assign bus.seq_err  = r_seq_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_payload      <= '0;
      r_bit_cnt      <= '0;
      r_gap_cnt      <= '0;
      r_rx_cnt       <= '0;
      r_rx_sr        <= '0;
      r_ss_n         <= 1'b1;
      r_mosi         <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_rd_valid     <= 1'b0;
      r_rd_data      <= '0;
      r_seq_err      <= 1'b0;
      r_rd_addr_seen <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_seq_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_payload <= {bus.req_cmd, bus.req_data};
            r_state   <= S_START;
            r_ss_n    <= 1'b0;
            r_mosi    <= 1'b0;
            r_busy    <= 1'b1;
            r_seq_err <= (bus.req_cmd == 2'b11) && !r_rd_addr_seen;
          end
        end
        S_START: begin
          // Select bit is the read/write flag, i.e. the payload MSB.
          r_state <= S_SEL;
          r_mosi  <= r_payload[PW-1];
        end
        S_SEL: begin
          r_state   <= S_SHIFT;
          r_mosi    <= r_payload[PW-1];
          r_bit_cnt <= 4'(PW - 1);
        end
        S_SHIFT: begin
          if (r_bit_cnt == 4'd0) begin
            r_mosi <= 1'b0;
            if (w_is_rd_data) begin
              r_state   <= S_GAP;
              r_gap_cnt <= 4'(RD_GAP - 1);
            end else begin
              r_state <= S_END;
              r_ss_n  <= 1'b1;
              r_done  <= 1'b1;
              if (w_is_rd_addr) r_rd_addr_seen <= 1'b1;
            end
          end else begin
            r_mosi    <= r_payload[r_bit_cnt - 4'd1];
            r_bit_cnt <= r_bit_cnt - 4'd1;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == 4'd0) begin
            r_state  <= S_RECV;
            r_rx_cnt <= 4'(ADDR_SIZE - 1);
          end else begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
          end
        end
        S_RECV: begin
          r_rx_sr <= {r_rx_sr[ADDR_SIZE-3:0], bus.MISO};
          if (r_rx_cnt == 4'd0) begin
            r_state        <= S_END;
            r_rd_data      <= {r_rx_sr, bus.MISO};
            r_ss_n         <= 1'b1;
            r_done         <= 1'b1;
            r_rd_valid     <= 1'b1;
            r_rd_addr_seen <= 1'b0;
          end else begin
            r_rx_cnt <= r_rx_cnt - 4'd1;
          end
        end
        S_END: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Randomised self-checking bench for spi_master_ctrl; expected pin waveforms are
// computed per frame from cycle offsets relative to the accept edge.
module tb_spi_master_ctrl;

  localparam int AW = 8;
  localparam int G  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   done_cyc = 0;

  // Reference state: read-address-latched flag and last captured byte.
  bit          m_seen = 1'b0;
  logic [7:0]  m_rd   = 8'h00;

  spi_master_ctrl_if #(.ADDR_SIZE(AW)) bus ();

  spi_master_ctrl #(.ADDR_SIZE(AW), .RD_GAP(G)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed vector: {SS_n, MOSI, done, rd_valid, busy, seq_err, req_ready, rd_data}
  function automatic logic [14:0] obs();
    return {bus.SS_n, bus.MOSI, bus.done, bus.rd_valid, bus.busy,
            bus.seq_err, bus.req_ready, bus.rd_data};
  endfunction

  // Runs one frame and checks every cycle from the accept edge to the return to idle.
  task automatic run_frame(input logic [1:0] cmd, input logic [7:0] data,
                           input logic [7:0] miso_byte, input bit hold);
    int          len;
    int          w;
    bit          rd;
    bit          seq_exp;
    logic [9:0]  pay;
    logic [7:0]  new_rd;
    logic [14:0] exp_v;
    logic [14:0] got_v;
    logic        e_ss, e_mosi, e_done;
    rd  = (cmd == 2'b11);
    len = rd ? (20 + G) : 12;
    pay = {cmd, data};
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_cmd   = cmd;
    bus.req_data  = data;
    w = 0;
    while (bus.req_ready !== 1'b1 && w < 60) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (w >= 60) begin
      n_err++;
      $display("FAIL accept_timeout cmd=%b req_ready=%b required=1", cmd, bus.req_ready);
      bus.req_valid = 1'b0;
      return;
    end
    seq_exp = rd && !m_seen;
    new_rd  = rd ? miso_byte : m_rd;
    @(posedge clk);
    #1;
    if (!hold) bus.req_valid = 1'b0;
    bus.req_cmd  = 2'($urandom);
    bus.req_data = 8'($urandom);
    for (int k = 0; k <= len + 1; k++) begin
      if (k > 0) begin
        @(negedge clk);
        if (rd && k >= 13 + G && k <= 20 + G)
          bus.MISO = miso_byte[7 - (k - 13 - G)];
        else
          bus.MISO = 1'($urandom);
        @(posedge clk);
        #1;
      end
      e_ss   = (k >= len);
      if (k == 1)                e_mosi = cmd[1];
      else if (k >= 2 && k <= 11) e_mosi = pay[11 - k];
      else                        e_mosi = 1'b0;
      e_done = (k == len);
      exp_v = {e_ss, e_mosi, e_done, e_done && rd, 1'(k <= len),
               1'((k == 0) && seq_exp), 1'(k > len), (k >= len) ? new_rd : m_rd};
      got_v = obs();
      if (e_done && bus.done === 1'b1) done_cyc = cyc;
      n_checks++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL frame cmd=%b data=%h k=%0d got{ss,mosi,done,rv,busy,seq,rdy,rd}=%b required=%b",
                 cmd, data, k, got_v, exp_v);
      end
    end
    if (cmd == 2'b10) m_seen = 1'b1;
    else if (rd)      m_seen = 1'b0;
    m_rd = new_rd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (obs() !== 15'b100_0000_0000_0000) begin
      n_err++;
      $display("FAIL reset_state got=%b required=%b", obs(), 15'b100_0000_0000_0000);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready !== 1'b1 || bus.SS_n !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release req_ready=%b SS_n=%b required 1 1", bus.req_ready, bus.SS_n);
    end
    m_seen = 1'b0;
    m_rd   = 8'h00;
  endtask

  task automatic test_write_a5();
    run_frame(2'b00, 8'hA5, 8'h00, 1'b0);
  endtask

  task automatic test_read_seq();
    run_frame(2'b10, 8'h3C, 8'h00, 1'b0);
    run_frame(2'b11, 8'h00, 8'h5A, 1'b0);
  endtask

  task automatic test_seq_err();
    // m_seen is 0 after reset, so both reads expect a seq_err pulse.
    run_frame(2'b11, 8'h77, 8'h81, 1'b0);
    run_frame(2'b11, 8'h00, 8'h3E, 1'b0);
  endtask

  task automatic test_reset_mid_shift();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_cmd   = 2'b01;
    bus.req_data  = 8'($urandom);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.SS_n, bus.MOSI, bus.busy, bus.done} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_mid_shift {ss,mosi,busy,done}=%b required=1000",
               {bus.SS_n, bus.MOSI, bus.busy, bus.done});
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.done !== 1'b0) begin
        n_err++;
        $display("FAIL reset_no_done cycle=%0d done=%b required=0", i, bus.done);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    m_seen = 1'b0;
    m_rd   = 8'h00;
    run_frame(2'b00, 8'($urandom), 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back();
    int prev;
    run_frame(2'b10, 8'h11, 8'h00, 1'b1);
    for (int i = 0; i < 6; i++) begin
      prev = done_cyc;
      run_frame((i % 2 == 0) ? 2'b01 : 2'b00, 8'($urandom), 8'h00, i != 5);
      n_checks++;
      if (done_cyc - prev != 14) begin
        n_err++;
        $display("FAIL back_to_back_spacing frame=%0d got=%0d required=14", i, done_cyc - prev);
      end
    end
  endtask

  task automatic test_miso_noise();
    run_frame(2'b10, 8'h42, 8'h00, 1'b0);
    run_frame(2'b11, 8'hFF, 8'hCA, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++)
      run_frame(2'($urandom), 8'($urandom), 8'($urandom), 1'b0);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_cmd   = 2'b00;
    bus.req_data  = 8'h00;
    bus.MISO      = 1'b0;
    test_reset();
    test_seq_err();
    test_write_a5();
    test_read_seq();
    test_reset_mid_shift();
    test_back_to_back();
    test_miso_noise();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
